// File: rtl/cpu_pkg.sv
// Shared types and defaults for the memory-access stage.
package cpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  localparam int          WB_SIZE    = 2;
  localparam int          ADDR_WIDTH = 12;
  localparam logic [31:0] SP_INIT    = 32'h0000_0FFF;

  // Operation fields held across the second beat of a wide transfer.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        stack;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [15:0] alu;
    logic [2:0]  rdst;
  } op_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: the stage drives address/strobe/data, memory returns a
// combinational read word.
interface mem_stage_if #(
  parameter int AddrWidth = 12
);
  logic [AddrWidth-1:0] mem_addr;
  logic                 mem_we;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/sp_unit.sv
// Stack pointer register with a +/-1 or +/-2 update. Arithmetic wraps mod 2^32.
module sp_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] SpInit = SP_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  input  logic        two,
  output logic [31:0] sp
);

  logic [31:0] sp_q, sp_d;
  logic [31:0] amt;

  // next SP: increment wins if both are ever requested together
  always_comb begin
    amt  = two ? 32'd2 : 32'd1;
    sp_d = sp_q;
    if (inc)      sp_d = sp_q + amt;
    else if (dec) sp_d = sp_q - amt;
  end

  // SP register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= SpInit;
    else     sp_q <= sp_d;
  end

  assign sp = sp_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads, stores, push/pop, and 32-bit
// transfers split into two 16-bit beats with a one-cycle front-end stall.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int          WbSize    = WB_SIZE,
  parameter int          AddrWidth = ADDR_WIDTH,
  parameter logic [31:0] SpInit    = SP_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic              i_stack,
  input  logic              i_wide,
  input  logic [15:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [WbSize-1:0] i_WB,
  input  logic [15:0]       i_alu,
  input  logic [2:0]        i_Rdst,
  mem_stage_if.master       mem,
  output logic              o_stall,
  output logic              o_valid,
  output logic [WbSize-1:0] o_WB,
  output logic [31:0]       o_MemData,
  output logic [15:0]       o_alu,
  output logic [2:0]        o_Rdst,
  output logic [31:0]       o_SP
);

  state_e               state_q, state_d;
  op_t                  op_q, op_d, cur;
  logic [WbSize-1:0]    wb_q, wb_d, cur_wb;
  logic [15:0]          first_q, first_d;
  logic                 second, act, is_mem, is_wr, is_rd, wide_first;
  logic                 sp_inc, sp_dec, sp_two;
  logic [31:0]          sp;
  logic [AddrWidth-1:0] ea;

  sp_unit #(.SpInit(SpInit)) u_sp (
    .clk (clk),
    .rst (rst),
    .inc (sp_inc),
    .dec (sp_dec),
    .two (sp_two),
    .sp  (sp)
  );

  // operand select: latched op during SECOND, live inputs otherwise;
  // reset masks live activity so strobes drop immediately
  always_comb begin
    second = (state_q == SECOND);
    cur    = '{rd: i_memRead, wr: i_memWrite, stack: i_stack, addr: i_addr,
               wdata: i_wdata, alu: i_alu, rdst: i_Rdst};
    cur_wb = i_WB;
    act    = i_valid & ~rst;
    if (second) begin
      cur    = op_q;
      cur_wb = wb_q;
      act    = 1'b1;
    end
    is_mem     = cur.rd | cur.wr;
    is_wr      = cur.wr;             // write wins when both strobes are set
    is_rd      = cur.rd & ~cur.wr;
    wide_first = ~second & act & i_wide & is_mem;
  end

  assign o_stall = wide_first;

  // address and write word; high word always goes out on the first beat
  always_comb begin
    ea = '0;
    if (cur.stack) begin
      if (is_wr) ea = second ? AddrWidth'(sp - 32'd1) : AddrWidth'(sp);
      else       ea = second ? AddrWidth'(sp + 32'd2) : AddrWidth'(sp + 32'd1);
    end else begin
      ea = second ? AddrWidth'(cur.addr + 16'd1) : AddrWidth'(cur.addr);
    end
    mem.mem_addr  = ea;
    mem.mem_we    = act & is_wr;
    mem.mem_wdata = wide_first ? cur.wdata[31:16] : cur.wdata[15:0];
  end

  // result assembly: pops put the low word first, plain loads the high word
  always_comb begin
    o_MemData = '0;
    if (act & is_rd) begin
      if (second)
        o_MemData = cur.stack ? {mem.mem_rdata, first_q} : {first_q, mem.mem_rdata};
      else if (!wide_first)
        o_MemData = {16'h0, mem.mem_rdata};
    end
    o_valid = act & ~wide_first;
    o_WB    = o_valid ? cur_wb : '0;
    o_alu   = cur.alu;
    o_Rdst  = cur.rdst;
  end

  // SP update: narrow ops commit at once, wide ops commit +/-2 on SECOND
  always_comb begin
    sp_inc = 1'b0;
    sp_dec = 1'b0;
    sp_two = second;
    if (act & cur.stack & ~wide_first) begin
      sp_inc = is_rd;
      sp_dec = is_wr;
    end
  end

  assign o_SP = sp;

  // next state: latch the op and the first read word on entry to SECOND
  always_comb begin
    state_d = IDLE;
    op_d    = op_q;
    wb_d    = wb_q;
    first_d = first_q;
    if (wide_first) begin
      state_d = SECOND;
      op_d    = cur;
      wb_d    = cur_wb;
      if (is_rd) first_d = mem.mem_rdata;
    end
  end

  // state and latched-operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      wb_q    <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural 4K x 16 data memory.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_memRead, i_memWrite, i_stack, i_wide;
  logic [15:0] i_addr, i_alu;
  logic [31:0] i_wdata;
  logic [1:0]  i_WB;
  logic [2:0]  i_Rdst;
  logic        o_stall, o_valid;
  logic [1:0]  o_WB;
  logic [31:0] o_MemData, o_SP;
  logic [15:0] o_alu;
  logic [2:0]  o_Rdst;
  logic [15:0] mem_arr [0:4095];
  int          tests = 0;
  int          fails = 0;

  mem_stage_if #(.AddrWidth(12)) mif ();

  assign mif.mem_rdata = mem_arr[mif.mem_addr];

  always @(posedge clk) if (mif.mem_we) mem_arr[mif.mem_addr] <= mif.mem_wdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_stack(i_stack), .i_wide(i_wide),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_WB(i_WB), .i_alu(i_alu),
    .i_Rdst(i_Rdst), .mem(mif.master), .o_stall(o_stall), .o_valid(o_valid),
    .o_WB(o_WB), .o_MemData(o_MemData), .o_alu(o_alu), .o_Rdst(o_Rdst),
    .o_SP(o_SP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    i_valid = 0; i_memRead = 0; i_memWrite = 0; i_stack = 0; i_wide = 0;
    i_addr = '0; i_wdata = '0; i_WB = '0; i_alu = '0; i_Rdst = '0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic stk, input logic wide,
                    input logic [15:0] addr, input logic [31:0] wd);
    i_valid = 1; i_memRead = rd; i_memWrite = wr; i_stack = stk; i_wide = wide;
    i_addr = addr; i_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    #12;
    chk("rst_sp", o_SP, 32'h0000_0FFF);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
    chk("rst_memdata", o_MemData, 32'd0);
    @(negedge clk) rst = 1'b0;

    // narrow push, then async reset in the middle of a cycle
    op(0, 1, 1, 0, 16'h0, 32'h0000_AAAA);
    #1;
    chk("npush_we", {31'd0, mif.mem_we}, 32'd1);
    chk("npush_addr", {20'd0, mif.mem_addr}, 32'h0FFF);
    @(negedge clk);
    chk("npush_sp", o_SP, 32'h0000_0FFE);
    op(0, 1, 1, 1, 16'h0, 32'h1111_2222);
    #1 chk("pre_rst_stall", {31'd0, o_stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sp", o_SP, 32'h0000_0FFF);
    chk("midrst_stall", {31'd0, o_stall}, 32'd0);
    chk("midrst_we", {31'd0, mif.mem_we}, 32'd0);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk) begin rst = 1'b0; clr(); end

    // narrow store / load
    op(0, 1, 0, 0, 16'h0010, 32'h0000_BEEF);
    #1;
    chk("st_we", {31'd0, mif.mem_we}, 32'd1);
    chk("st_addr", {20'd0, mif.mem_addr}, 32'h010);
    chk("st_wdata", {16'd0, mif.mem_wdata}, 32'hBEEF);
    chk("st_valid", {31'd0, o_valid}, 32'd1);
    @(negedge clk);
    op(1, 0, 0, 0, 16'h0010, 32'h0);
    i_WB = 2'b10; i_alu = 16'h1357; i_Rdst = 3'd5;
    #1;
    chk("ld_data", o_MemData, 32'h0000_BEEF);
    chk("ld_valid", {31'd0, o_valid}, 32'd1);
    chk("ld_stall", {31'd0, o_stall}, 32'd0);
    chk("ld_we", {31'd0, mif.mem_we}, 32'd0);
    chk("ld_wb", {30'd0, o_WB}, 32'd2);
    chk("ld_alu", {16'd0, o_alu}, 32'h1357);
    chk("ld_rdst", {29'd0, o_Rdst}, 32'd5);

    // wide push at SP=0FFF; live inputs dropped during SECOND
    @(negedge clk) clr();
    op(0, 1, 1, 1, 16'h0, 32'h1234_5678);
    i_WB = 2'b11;
    #1;
    chk("wpush1_stall", {31'd0, o_stall}, 32'd1);
    chk("wpush1_addr", {20'd0, mif.mem_addr}, 32'hFFF);
    chk("wpush1_wdata", {16'd0, mif.mem_wdata}, 32'h1234);
    chk("wpush1_valid", {31'd0, o_valid}, 32'd0);
    chk("wpush1_wb", {30'd0, o_WB}, 32'd0);
    @(negedge clk) clr();
    #1;
    chk("wpush2_stall", {31'd0, o_stall}, 32'd0);
    chk("wpush2_we", {31'd0, mif.mem_we}, 32'd1);
    chk("wpush2_addr", {20'd0, mif.mem_addr}, 32'hFFE);
    chk("wpush2_wdata", {16'd0, mif.mem_wdata}, 32'h5678);
    chk("wpush2_valid", {31'd0, o_valid}, 32'd1);
    chk("wpush2_wb", {30'd0, o_WB}, 32'd3);
    chk("wpush2_sp_hold", o_SP, 32'h0000_0FFF);

    // wide pop
    @(negedge clk);
    chk("mem_fff", {16'd0, mem_arr[12'hFFF]}, 32'h1234);
    chk("mem_ffe", {16'd0, mem_arr[12'hFFE]}, 32'h5678);
    chk("wpush_sp", o_SP, 32'h0000_0FFD);
    op(1, 0, 1, 1, 16'h0, 32'h0);
    #1;
    chk("wpop1_stall", {31'd0, o_stall}, 32'd1);
    chk("wpop1_addr", {20'd0, mif.mem_addr}, 32'hFFE);
    chk("wpop1_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk) clr();
    #1;
    chk("wpop2_addr", {20'd0, mif.mem_addr}, 32'hFFF);
    chk("wpop2_data", o_MemData, 32'h1234_5678);
    chk("wpop2_valid", {31'd0, o_valid}, 32'd1);

    // back-to-back wide non-stack load, address truncated to 12 bits
    @(negedge clk);
    chk("wpop_sp", o_SP, 32'h0000_0FFF);
    op(1, 0, 0, 1, 16'hFFFE, 32'h0);
    #1;
    chk("wld1_stall", {31'd0, o_stall}, 32'd1);
    chk("wld1_addr", {20'd0, mif.mem_addr}, 32'hFFE);
    @(negedge clk) clr();
    #1;
    chk("wld2_addr", {20'd0, mif.mem_addr}, 32'hFFF);
    chk("wld2_data", o_MemData, 32'h5678_1234);
    chk("wld2_valid", {31'd0, o_valid}, 32'd1);

    // 4096 narrow pushes walk SP from 0FFF to FFFF_FFFF; then pop wraps to 0
    @(negedge clk);
    op(0, 1, 1, 0, 16'h0, 32'h0000_5A5A);
    repeat (4096) @(posedge clk);
    @(negedge clk);
    chk("wrap_sp_pre", o_SP, 32'hFFFF_FFFF);
    op(1, 0, 1, 0, 16'h0, 32'h0);
    #1;
    chk("wrap_addr", {20'd0, mif.mem_addr}, 32'h000);
    chk("wrap_data", o_MemData, 32'h0000_5A5A);
    @(negedge clk) clr();
    chk("wrap_sp_post", o_SP, 32'h0000_0000);

    // reset during SECOND of a wide push
    rst = 1'b1;
    #2 rst = 1'b0;
    chk("rst2_sp", o_SP, 32'h0000_0FFF);
    @(negedge clk);
    op(0, 1, 1, 1, 16'h0, 32'hCAFE_F00D);
    @(negedge clk) clr();
    #1;
    chk("rsec_we_pending", {31'd0, mif.mem_we}, 32'd1);
    chk("rsec_addr", {20'd0, mif.mem_addr}, 32'hFFE);
    rst = 1'b1;
    #1;
    chk("rsec_we", {31'd0, mif.mem_we}, 32'd0);
    chk("rsec_sp", o_SP, 32'h0000_0FFF);
    chk("rsec_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rsec_mem_fff", {16'd0, mem_arr[12'hFFF]}, 32'hCAFE);
    chk("rsec_mem_ffe", {16'd0, mem_arr[12'hFFE]}, 32'h5A5A);
    chk("rsec_sp_after", o_SP, 32'h0000_0FFF);
    chk("rsec_idle_we", {31'd0, mif.mem_we}, 32'd0);

    // read+write conflict, then a bubble
    @(negedge clk);
    op(1, 1, 0, 0, 16'h0020, 32'h0000_1111);
    i_WB = 2'b01;
    #1;
    chk("conf_we", {31'd0, mif.mem_we}, 32'd1);
    chk("conf_data", o_MemData, 32'd0);
    chk("conf_valid", {31'd0, o_valid}, 32'd1);
    chk("conf_wb", {30'd0, o_WB}, 32'd1);
    @(negedge clk);
    chk("conf_mem", {16'd0, mem_arr[12'h020]}, 32'h1111);
    op(0, 1, 1, 0, 16'h0020, 32'h0000_2222);
    i_valid = 1'b0; i_WB = 2'b11;
    #1;
    chk("bub_we", {31'd0, mif.mem_we}, 32'd0);
    chk("bub_valid", {31'd0, o_valid}, 32'd0);
    chk("bub_wb", {30'd0, o_WB}, 32'd0);
    @(negedge clk);
    chk("bub_sp", o_SP, 32'h0000_0FFF);
    chk("bub_mem", {16'd0, mem_arr[12'h020]}, 32'h1111);
    clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
